// File: rtl/ymem_wr_arbiter.sv
// Round-robin write-port arbiter for the banked Y line store; bank index = requester index.
// Define WR_DROP_CNT_EN to add the saturating drop_cnt output.
module ymem_wr_arbiter #(
  parameter int NREQ  = 4,
  parameter int DW    = 12,
  parameter int AW    = 16,
  parameter int DEPTH = 38400
) (
  input  logic                    Cclk,
  input  logic                    rst,
  input  logic                    frame_sync,
  input  logic                    rd_slot,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*DW-1:0]      req_data,
  input  logic [NREQ*AW-1:0]      req_addr,
  output logic                    mem_we,
  output logic [$clog2(NREQ)-1:0] mem_bank,
  output logic [AW-1:0]           mem_addr,
  output logic [DW-1:0]           mem_data,
  output logic                    drop_err
`ifdef WR_DROP_CNT_EN
  ,
  output logic [15:0]             drop_cnt
`endif
);

  localparam int BW = $clog2(NREQ);
  localparam logic [AW-1:0] DEPTH_A   = AW'(DEPTH);
  localparam logic [BW-1:0] LAST_INIT = BW'(NREQ - 1);

  // Handshake: a word moves on an edge where req_valid[i] & req_ready[i] are both high;
  // data and address must stay stable while valid is high and ready is low.
  logic [NREQ-1:0] hold_v;
  logic [DW-1:0]   hold_d [NREQ];
  logic [AW-1:0]   hold_a [NREQ];
  logic [AW-1:0]   wp0;
  logic [BW-1:0]   last_gnt;

  logic [NREQ-1:0] gnt;
  logic            gnt_any;
  logic [BW-1:0]   gnt_idx;
  logic [BW-1:0]   cand;
  int              cand_sum;
  logic [NREQ-1:0] accept;
  logic            drop_now;
  logic [AW-1:0]   wp0_inc;
  logic [AW-1:0]   addr0;
  logic            unused_addr0;

  // Requester 0 is auto-addressed, so its address slice carries nothing.
  assign unused_addr0 = ^req_addr[AW-1:0];

  // Scan starts one past the last grant so every requester waits at most NREQ-1 grants.
  always_comb begin
    gnt_any  = 1'b0;
    gnt_idx  = '0;
    cand     = '0;
    cand_sum = 0;
    for (int k = 1; k <= NREQ; k++) begin
      cand_sum = int'(last_gnt) + k;
      if (cand_sum >= NREQ) cand_sum = cand_sum - NREQ;
      cand = BW'(cand_sum);
      if (!gnt_any && !rd_slot && hold_v[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  always_comb begin
    gnt = '0;
    if (gnt_any) gnt[gnt_idx] = 1'b1;
  end

  assign req_ready = ~hold_v | gnt;
  assign accept    = req_valid & req_ready;
  assign drop_now  = gnt_any && (hold_a[gnt_idx] >= DEPTH_A);
  assign wp0_inc   = (wp0 >= DEPTH_A) ? DEPTH_A : wp0 + AW'(1);
  assign addr0     = frame_sync ? '0 : wp0;

  always_ff @(posedge Cclk) begin
    if (rst) begin
      hold_v   <= '0;
      wp0      <= '0;
      last_gnt <= LAST_INIT;
      mem_we   <= 1'b0;
      mem_bank <= '0;
      mem_addr <= '0;
      mem_data <= '0;
      drop_err <= 1'b0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (accept[i])   hold_v[i] <= 1'b1;
        else if (gnt[i]) hold_v[i] <= 1'b0;
      end

      // A frame_sync that lands on an accept places that word at 0, so the next one is 1.
      if (accept[0])       wp0 <= frame_sync ? AW'(1) : wp0_inc;
      else if (frame_sync) wp0 <= '0;

      mem_we   <= gnt_any && !drop_now;
      drop_err <= drop_now;
      if (gnt_any) begin
        last_gnt <= gnt_idx;
        if (!drop_now) begin
          mem_bank <= gnt_idx;
          mem_addr <= hold_a[gnt_idx];
          mem_data <= hold_d[gnt_idx];
        end
      end
    end
  end

  always_ff @(posedge Cclk) begin
    for (int i = 0; i < NREQ; i++) begin
      if (accept[i]) begin
        hold_d[i] <= req_data[i*DW +: DW];
        hold_a[i] <= (i == 0) ? addr0 : req_addr[i*AW +: AW];
      end
    end
  end

`ifdef WR_DROP_CNT_EN
  always_ff @(posedge Cclk) begin
    if (rst || frame_sync)                 drop_cnt <= '0;
    else if (drop_now && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
  end
`endif

endmodule
